common_dffram_1a1wb1r_ctrl: RTL and testbench

//  Requester-side controller for a single-port bit-write-enable DFF RAM (1 addr, 1 wr, 1 comb. rd port).

---
 rtl/common_dffram_1a1wb1r_ctrl_pkg.sv | 10 +
 rtl/common_dffram_ctrl_sweep.sv | 34 +++
 rtl/common_dffram_1a1wb1r_ctrl.sv | 150 +++++++++++++++
 tb/tb_common_dffram_1a1wb1r_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_dffram_1a1wb1r_ctrl_pkg.sv
// Shared types for the 1a1wb1r DFF RAM controller.
// Controller states: SWEEP fills the RAM with FILL_VALUE, RUN serves requests.
package common_dffram_1a1wb1r_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/common_dffram_ctrl_sweep.sv
// Sweep address counter for the DFF RAM controller.
// Only built when COMMON_DFFRAM_CTRL_SWEEP_EN is defined.
`ifdef COMMON_DFFRAM_CTRL_SWEEP_EN
module common_dffram_ctrl_sweep #(
    parameter int unsigned ADDR_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  done
);

    logic [ADDR_WIDTH-1:0] count_r;

    // Address counter: steps once per sweep cycle and wraps to 0 after the last entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (start) begin
            count_r <= count_r + ADDR_WIDTH'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign done  = (count_r == {ADDR_WIDTH{1'b1}});

endmodule
`endif

// File: rtl/common_dffram_1a1wb1r_ctrl.sv
// Requester-side controller for a single-port bit-write-enable DFF RAM.
// Turns a valid/ready request stream into RAM strobes and returns read data
// through a one-entry registered response slot.
// Optional power-up/flush fill sweep: define COMMON_DFFRAM_CTRL_SWEEP_EN.
module common_dffram_1a1wb1r_ctrl
    import common_dffram_1a1wb1r_ctrl_pkg::*;
#(
    parameter int unsigned               RAM_DATA_WIDTH = 1,
    parameter int unsigned               RAM_ADDR_WIDTH = 1,
    parameter logic [RAM_DATA_WIDTH-1:0] FILL_VALUE     = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [RAM_ADDR_WIDTH-1:0] req_addr,
    input  logic [RAM_DATA_WIDTH-1:0] req_wmask,
    input  logic [RAM_DATA_WIDTH-1:0] req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [RAM_DATA_WIDTH-1:0] rsp_rdata,
    input  logic                      flush,
    output logic                      busy,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic                      ram_en,
    output logic [RAM_DATA_WIDTH-1:0] ram_we,
    output logic [RAM_DATA_WIDTH-1:0] ram_din,
    input  logic [RAM_DATA_WIDTH-1:0] ram_dout
);

    logic                      sweeping_s;
    logic                      flush_run_s;
    logic [RAM_ADDR_WIDTH-1:0] sweep_count_s;
    logic                      accept_s;
    logic                      rd_accept_s;

`ifdef COMMON_DFFRAM_CTRL_SWEEP_EN
    ctrl_state_e state_r;
    ctrl_state_e state_s;
    logic        sweep_done_s;

    assign sweeping_s  = (state_r == ST_SWEEP);
    // A flush only counts in RUN; during a sweep it is ignored.
    assign flush_run_s = (state_r == ST_RUN) & flush;
    assign busy        = sweeping_s;

    common_dffram_ctrl_sweep #(
        .ADDR_WIDTH (RAM_ADDR_WIDTH)
    ) u_sweep (
        .clk   (clk),
        .reset (reset),
        .start (sweeping_s),
        .clear (flush_run_s),
        .count (sweep_count_s),
        .done  (sweep_done_s)
    );

    // State register; reset lands in SWEEP so the RAM is filled after power-up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_SWEEP;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state: leave SWEEP after the last address, re-enter on a RUN flush.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_SWEEP: begin
                if (sweep_done_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_SWEEP;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_s = ST_SWEEP;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_SWEEP;
        endcase
    end
`else
    logic unused_flush_s;

    // Without the sweep the controller is permanently in RUN and flush is dropped.
    assign sweeping_s     = 1'b0;
    assign flush_run_s    = 1'b0;
    assign sweep_count_s  = '0;
    assign busy           = 1'b0;
    assign unused_flush_s = flush;
`endif

    // RAM port mux and request handshake: sweep writes, then RUN requests.
    always_comb begin
        req_ready   = 1'b0;
        ram_addr    = req_addr;
        ram_din     = req_wdata;
        ram_en      = 1'b0;
        ram_we      = '0;
        accept_s    = 1'b0;
        rd_accept_s = 1'b0;
        if (sweeping_s) begin
            ram_addr = sweep_count_s;
            ram_din  = FILL_VALUE;
            ram_en   = 1'b1;
            ram_we   = {RAM_DATA_WIDTH{1'b1}};
        end else if (flush_run_s) begin
            req_ready = 1'b0;
        end else begin
            // Writes never need the response slot; reads need it free or draining.
            req_ready = req_write | ~rsp_valid | rsp_ready;
            accept_s  = req_valid & req_ready;
            if (accept_s) begin
                ram_en = 1'b1;
                if (req_write) begin
                    ram_we = req_wmask;
                end else begin
                    rd_accept_s = 1'b1;
                end
            end else begin
                ram_en = 1'b0;
            end
        end
    end

    // Response slot: capture RAM data on read accept, release on consumer handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (rd_accept_s) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= ram_dout;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= rsp_rdata;
        end else begin
            rsp_valid <= rsp_valid;
            rsp_rdata <= rsp_rdata;
        end
    end

endmodule

// File: tb/tb_common_dffram_1a1wb1r_ctrl.sv
// Bench for common_dffram_1a1wb1r_ctrl attached to a behavioural 1a1wb1r DFF RAM.
// Adapts to COMMON_DFFRAM_CTRL_SWEEP_EN: sweep scenarios with it, sweep-less scenarios without.
module tb_common_dffram_1a1wb1r_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 8;
    localparam logic [7:0]  FILL  = 8'hA5;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wmask, req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          flush, busy;
    logic [AW-1:0] ram_addr;
    logic          ram_en;
    logic [DW-1:0] ram_we, ram_din, ram_dout;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] got_q [$];
    logic [DW-1:0] exp_q [$];
    logic          s_busy, s_rsp_valid, s_req_ready;
    logic [DW-1:0] s_rsp_rdata;
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    common_dffram_1a1wb1r_ctrl #(
        .RAM_DATA_WIDTH (DW),
        .RAM_ADDR_WIDTH (AW),
        .FILL_VALUE     (FILL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wmask (req_wmask),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .flush     (flush),
        .busy      (busy),
        .ram_addr  (ram_addr),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Behavioural 1a1wb1r RAM: per-bit write enable, combinational read, own reset pattern.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'(i * 17);
        end else if (ram_en) begin
            mem[ram_addr] <= (mem[ram_addr] & ~ram_we) | (ram_din & ram_we);
        end
    end
    assign ram_dout = mem[ram_addr];

    task automatic model_ram_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i * 17);
    endtask

    task automatic model_fill();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = FILL;
    endtask

    // One cycle of stimulus: drive at negedge, sample 1ns later, update the reference model.
    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] m, input logic [DW-1:0] d,
                         input logic rr, input logic fl, output logic acc);
        @(negedge clk);
        req_valid = v; req_write = w; req_addr = a; req_wmask = m; req_wdata = d;
        rsp_ready = rr; flush = fl;
        #1;
        s_busy = busy; s_rsp_valid = rsp_valid; s_rsp_rdata = rsp_rdata; s_req_ready = req_ready;
        if (rsp_valid && rr) got_q.push_back(rsp_rdata);
        acc = v && req_ready;
`ifdef COMMON_DFFRAM_CTRL_SWEEP_EN
        if (fl && !busy) model_fill();
`endif
        if (acc) begin
            if (w) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
            else   exp_q.push_back(ref_mem[a]);
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
    endtask

    // Idle cycles counting how many sample points see busy, and busy cycles with req_ready high.
    task automatic count_busy(input int flush_at, output int n, output int rdy_bad);
        logic acc;
        n = 0; rdy_bad = 0;
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, (i == flush_at), acc);
            if (s_busy) begin
                n++;
                if (s_req_ready) rdy_bad++;
            end
        end
    endtask

    // Read every address once (bounded wait per read), then drain the response slot.
    task automatic read_all();
        logic acc;
        for (int a = 0; a < DEPTH; a++) begin
            acc = 1'b0;
            for (int t = 0; t < 40 && !acc; t++) drive(1'b1, 1'b0, 3'(a), 8'h00, 8'h00, 1'b1, 1'b0, acc);
            if (!acc) begin
                n_err++;
                $display("FAIL read_all_timeout addr %0d not accepted within 40 cycles", a);
            end
        end
        idle(2);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic test_reset();
        logic exp_busy;
`ifdef COMMON_DFFRAM_CTRL_SWEEP_EN
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wmask = '0; req_wdata = '0; rsp_ready = 1'b0; flush = 1'b0;
        model_ram_reset();
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
        n_vec++; if (rsp_rdata !== 8'h00) begin n_err++; $display("FAIL rst_rsp_rdata got %h want 00", rsp_rdata); end
        n_vec++; if (busy !== exp_busy) begin n_err++; $display("FAIL rst_busy got %b want %b", busy, exp_busy); end
    endtask

    task automatic test_startup();
        int n, bad;
        release_reset();
`ifdef COMMON_DFFRAM_CTRL_SWEEP_EN
        count_busy(-1, n, bad);
        n_vec++; if (n != DEPTH) begin n_err++; $display("FAIL startup_busy_cycles got %0d want %0d", n, DEPTH); end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL startup_req_ready_in_sweep got %0d want 0", bad); end
        model_fill();
`else
        idle(1);
        n_vec++; if (s_busy !== 1'b0) begin n_err++; $display("FAIL startup_busy got %b want 0", s_busy); end
        n_vec++; if (s_req_ready !== 1'b1) begin n_err++; $display("FAIL startup_req_ready got %b want 1", s_req_ready); end
`endif
        got_q.delete(); exp_q.delete();
        read_all();
        n_vec++; if (got_q.size() != DEPTH) begin n_err++; $display("FAIL startup_read_count got %0d want %0d", got_q.size(), DEPTH); end
        for (int i = 0; i < got_q.size() && i < DEPTH; i++) begin
`ifdef COMMON_DFFRAM_CTRL_SWEEP_EN
            n_vec++; if (got_q[i] !== FILL) begin n_err++; $display("FAIL startup_fill[%0d] got %h want %h", i, got_q[i], FILL); end
`else
            n_vec++; if (got_q[i] !== 8'(i * 17)) begin n_err++; $display("FAIL startup_ramrst[%0d] got %h want %h", i, got_q[i], 8'(i * 17)); end
`endif
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_masked_write();
        logic acc_w, acc_r;
        logic [DW-1:0] want;
        drive(1'b1, 1'b1, 3'd3, 8'h0F, 8'hFF, 1'b1, 1'b0, acc_w);
        want = ref_mem[3];
        drive(1'b1, 1'b0, 3'd3, 8'h00, 8'h00, 1'b1, 1'b0, acc_r);
        n_vec++; if (acc_w !== 1'b1 || acc_r !== 1'b1) begin n_err++; $display("FAIL mask_accept got w=%b r=%b want 1 1", acc_w, acc_r); end
        n_vec++; if (s_rsp_valid !== 1'b0) begin n_err++; $display("FAIL mask_no_wr_rsp got %b want 0", s_rsp_valid); end
        idle(1);
        n_vec++; if (s_rsp_valid !== 1'b1) begin n_err++; $display("FAIL mask_rsp_valid got %b want 1", s_rsp_valid); end
        n_vec++; if (s_rsp_rdata !== want) begin n_err++; $display("FAIL mask_rdata got %h want %h", s_rsp_rdata, want); end
`ifdef COMMON_DFFRAM_CTRL_SWEEP_EN
        n_vec++; if (s_rsp_rdata !== 8'hAF) begin n_err++; $display("FAIL mask_rdata_abs got %h want af", s_rsp_rdata); end
`endif
        idle(1);
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic acc;
        int bubbles = 0, not_acc = 0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 3'(i), 8'h00, 8'h00, 1'b1, 1'b0, acc);
            if (!acc) not_acc++;
            if (i > 0 && s_rsp_valid !== 1'b1) bubbles++;
        end
        drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, acc);
        n_vec++; if (not_acc != 0) begin n_err++; $display("FAIL b2b_accept got %0d refusals want 0", not_acc); end
        n_vec++; if (bubbles != 0 || s_rsp_valid !== 1'b1) begin n_err++; $display("FAIL b2b_bubbles got %0d last=%b want 0 1", bubbles, s_rsp_valid); end
        drive(1'b1, 1'b0, 3'd2, 8'h00, 8'h00, 1'b0, 1'b0, acc);
        n_vec++; if (acc !== 1'b0) begin n_err++; $display("FAIL bp_read_ready got %b want 0", acc); end
        drive(1'b1, 1'b1, 3'd5, 8'hF0, 8'h3C, 1'b0, 1'b0, acc);
        n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL bp_write_ready got %b want 1", acc); end
        idle(2);
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b2b_data[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_flush();
        logic acc;
        int n, bad;
        drive(1'b1, 1'b0, 3'd4, 8'h00, 8'h00, 1'b1, 1'b1, acc);
`ifdef COMMON_DFFRAM_CTRL_SWEEP_EN
        n_vec++; if (acc !== 1'b0) begin n_err++; $display("FAIL flush_wins got accept=%b want 0", acc); end
        count_busy(3, n, bad);
        n_vec++; if (n != DEPTH) begin n_err++; $display("FAIL flush_busy_cycles got %0d want %0d", n, DEPTH); end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL flush_req_ready_in_sweep got %0d want 0", bad); end
`else
        n_vec++; if (acc !== 1'b1 || s_busy !== 1'b0) begin n_err++; $display("FAIL flush_ignored got accept=%b busy=%b want 1 0", acc, s_busy); end
        idle(2);
`endif
        got_q.delete(); exp_q.delete();
        read_all();
        n_vec++; if (got_q.size() != DEPTH) begin n_err++; $display("FAIL flush_read_count got %0d want %0d", got_q.size(), DEPTH); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL flush_data[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

`ifdef COMMON_DFFRAM_CTRL_SWEEP_EN
    task automatic test_reset_mid_sweep();
        logic acc;
        int n, bad;
        drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b1, acc);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, acc);
        @(negedge clk);
        reset = 1'b0;
        model_ram_reset();
        #1;
        n_vec++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrst_state got busy=%b rsp_valid=%b want 1 0", busy, rsp_valid); end
        release_reset();
        count_busy(-1, n, bad);
        n_vec++; if (n != DEPTH) begin n_err++; $display("FAIL midrst_busy_cycles got %0d want %0d", n, DEPTH); end
        model_fill();
        got_q.delete(); exp_q.delete();
        read_all();
        for (int i = 0; i < got_q.size() && i < DEPTH; i++) begin
            n_vec++; if (got_q[i] !== FILL) begin n_err++; $display("FAIL midrst_fill[%0d] got %h want %h", i, got_q[i], FILL); end
        end
        got_q.delete(); exp_q.delete();
    endtask
`endif

    task automatic test_random();
        logic acc;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, acc);
        end
        idle(3);
        read_all();
        n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_data[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_startup();
        test_masked_write();
        test_back_to_back();
        test_flush();
`ifdef COMMON_DFFRAM_CTRL_SWEEP_EN
        test_reset_mid_sweep();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
